// File: rtl/block_store.sv
// block_store: packs speculated subpaths into SpecCFA block memory as a {id,len} header followed by src/dest pairs.
// Latency: header one cycle after blk_start is accepted, 2 cycles per pair, blk_done >= 2*len+2 cycles after accept.
// Backpressure: blk_ready only in IDLE, ent_ready only in SRC. Option BLOCK_STORE_ENDMARK_EN adds a zero end-marker word.
module block_store #(
  parameter int         AW      = 16,
  parameter logic [7:0] MAX_LEN = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [AW-1:0] BLOCKMEM_size,
  input  logic          blk_start,
  input  logic [7:0]    blk_id,
  input  logic [7:0]    blk_len,
  output logic          blk_ready,
  input  logic          ent_valid,
  input  logic [15:0]   ent_src,
  input  logic [15:0]   ent_dest,
  output logic          ent_ready,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [AW-1:0] write_base,
  output logic          blk_done,
  output logic          err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_SRC  = 3'd2;
  localparam logic [2:0] S_DEST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef BLOCK_STORE_ENDMARK_EN
  localparam logic [2:0] S_MARK = 3'd5;
  localparam logic [2:0] S_TAIL = S_MARK;
`else
  localparam logic [2:0] S_TAIL = S_DONE;
`endif

  logic [2:0]    state;
  logic [7:0]    cnt;
  logic [AW-1:0] ptr;
  logic [AW:0]   end_q;
  logic [15:0]   dest_q;
  logic [AW:0]   end_calc;
  logic [AW:0]   size_ext;
  logic          fits;
  logic          len_ok;

  assign size_ext = {1'b0, BLOCKMEM_size};
  // One bit wider than the address so an oversized block cannot wrap into a false fit.
  assign end_calc = {1'b0, write_base} + {{(AW-8){1'b0}}, blk_len, 1'b0} + (AW+1)'(1);
  // With the end marker, end<size leaves room for it and end==size skips it, so both builds share end<=size.
  assign fits     = (end_calc <= size_ext);
  assign len_ok   = ({1'b0, blk_len} <= {1'b0, MAX_LEN});

  assign blk_ready = (state == S_IDLE);
  assign ent_ready = (state == S_SRC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      write_base <= '0;
      cnt        <= '0;
      ptr        <= '0;
      end_q      <= '0;
      dest_q     <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      blk_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_wen  <= 1'b0;
      blk_done <= 1'b0;
      if (clear) begin
        state      <= S_IDLE;
        write_base <= '0;
        cnt        <= '0;
        err        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (blk_start) begin
              if (!fits || !len_ok) begin
                err <= 1'b1;
              end else begin
                cnt       <= blk_len;
                end_q     <= end_calc;
                mem_wen   <= 1'b1;
                mem_addr  <= write_base;
                mem_wdata <= {blk_id, blk_len};
                state     <= S_HDR;
              end
            end
          end
          S_HDR: begin
            ptr   <= write_base + AW'(1);
            state <= (cnt == 8'd0) ? S_TAIL : S_SRC;
          end
          S_SRC: begin
            if (ent_valid) begin
              mem_wen   <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= ent_src;
              dest_q    <= ent_dest;
              ptr       <= ptr + AW'(1);
              state     <= S_DEST;
            end
          end
          S_DEST: begin
            mem_wen   <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= dest_q;
            ptr       <= ptr + AW'(1);
            cnt       <= cnt - 8'd1;
            state     <= (cnt == 8'd1) ? S_TAIL : S_SRC;
          end
`ifdef BLOCK_STORE_ENDMARK_EN
          S_MARK: begin
            if (end_q != size_ext) begin
              mem_wen   <= 1'b1;
              mem_addr  <= end_q[AW-1:0];
              mem_wdata <= '0;
            end
            state <= S_DONE;
          end
`endif
          S_DONE: begin
            blk_done   <= 1'b1;
            // Same wrap rule the fetcher applies when it reaches the end of memory.
            write_base <= (end_q == size_ext) ? '0 : end_q[AW-1:0];
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_store.sv
// Bench for block_store: table vectors, hand-written corner sequences and random blocks against a word-list model.
module tb_block_store;

  localparam int         AW   = 16;
  localparam logic [7:0] MAXL = 8'hF0;
`ifdef BLOCK_STORE_ENDMARK_EN
  localparam int MK = 1;
`else
  localparam int MK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, clear;
  logic [AW-1:0] size;
  logic          blk_start;
  logic [7:0]    blk_id, blk_len;
  logic          blk_ready;
  logic          ent_valid;
  logic [15:0]   ent_src, ent_dest;
  logic          ent_ready;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW-1:0] write_base;
  logic          blk_done;
  logic          err;

  block_store #(.AW(AW), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .clear(clear), .BLOCKMEM_size(size),
    .blk_start(blk_start), .blk_id(blk_id), .blk_len(blk_len), .blk_ready(blk_ready),
    .ent_valid(ent_valid), .ent_src(ent_src), .ent_dest(ent_dest), .ent_ready(ent_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .write_base(write_base), .blk_done(blk_done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] wr_q[$];
  int          done_cnt = 0;
  int          oob_cnt = 0;

  // Reference state: where the next block should land and whether an error is pending.
  logic [15:0] m_base;
  logic        m_err;
  int          last_nwr;

  always @(negedge clk) begin
    if (mem_wen) begin
      wr_q.push_back({mem_addr, mem_wdata});
      if (mem_addr >= size) oob_cnt++;
    end
    if (blk_done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_base = '0;
    m_err  = 1'b0;
    chk("clear_base", 32'(write_base), 32'h0);
    chk("clear_err", 32'(err), 32'h0);
    chk("clear_ready", 32'(blk_ready), 32'h1);
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting on DUT, got no handshake expected one", nm);
    do_clear();
  endtask

  // Drives one block and checks every written word, write_base, err and blk_done against the model.
  task automatic run_block(input logic [15:0] sz, input logic [7:0] id, input logic [7:0] len,
                           input bit rnd, input int gap_max);
    logic [15:0] src[256];
    logic [15:0] dst[256];
    logic [31:0] exp_q[$];
    int          e, t, w0, d0, nw;
    bit          acc;
    for (int i = 0; i < int'(len); i++) begin
      src[i] = rnd ? 16'($urandom) : 16'(16'hE150 + 16'(i * 32));
      dst[i] = rnd ? 16'($urandom) : 16'(src[i] + 16'h0010);
    end
    e   = int'(m_base) + 2 * int'(len) + 1;
    acc = (e <= int'(sz)) && (len <= MAXL);
    if (acc) begin
      exp_q.push_back({m_base, id, len});
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back({16'(int'(m_base) + 1 + 2 * i), src[i]});
        exp_q.push_back({16'(int'(m_base) + 2 + 2 * i), dst[i]});
      end
      if (MK == 1 && e != int'(sz)) exp_q.push_back({16'(e), 16'h0000});
    end
    size = sz;
    t = 0;
    while (!blk_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin timeout("wait_blk_ready"); return; end
    w0 = wr_q.size();
    d0 = done_cnt;
    blk_id = id; blk_len = len; blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
    if (acc) begin
      for (int i = 0; i < int'(len); i++) begin
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        ent_valid = 1'b1; ent_src = src[i]; ent_dest = dst[i];
        t = 0;
        while (!ent_ready && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) begin ent_valid = 1'b0; timeout("wait_ent_ready"); return; end
        @(negedge clk);
        ent_valid = 1'b0;
      end
      t = 0;
      while (!blk_done && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin timeout("wait_blk_done"); return; end
      @(negedge clk);
      m_base = (e == int'(sz)) ? 16'h0 : 16'(e);
    end else begin
      repeat (3) @(negedge clk);
      m_err = 1'b1;
    end
    nw = wr_q.size() - w0;
    last_nwr = nw;
    chk("write_count", 32'(nw), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < nw; k++)
      chk($sformatf("word%0d", k), wr_q[w0 + k], exp_q[k]);
    chk("write_base", 32'(write_base), 32'(m_base));
    chk("err", 32'(err), 32'(m_err));
    chk("done_pulses", 32'(done_cnt - d0), acc ? 32'h1 : 32'h0);
  endtask

  typedef struct {
    bit          clr;
    logic [15:0] sz;
    logic [7:0]  id;
    logic [7:0]  len;
    logic        exp_err;
    logic [15:0] exp_base;
    int          exp_nwr;
  } vec_t;

  vec_t tv[6];

  initial begin
    int t, w0, d0, len, rem;
    rst = 1'b1; clear = 1'b0; size = 16'h0040;
    blk_start = 1'b0; blk_id = '0; blk_len = '0;
    ent_valid = 1'b0; ent_src = '0; ent_dest = '0;
    m_base = '0; m_err = 1'b0; last_nwr = 0;

    tv[0] = '{1'b0, 16'h0040, 8'h03, 8'd2,   1'b0, 16'h0005, 5 + MK};
    tv[1] = '{1'b0, 16'h0040, 8'h07, 8'd0,   1'b0, 16'h0006, 1 + MK};
    tv[2] = '{1'b0, 16'h0008, 8'h01, 8'd1,   1'b1, 16'h0006, 0};
    tv[3] = '{1'b1, 16'h0005, 8'h0A, 8'd2,   1'b0, 16'h0000, 5};
    tv[4] = '{1'b0, 16'h0400, 8'h11, 8'hF1,  1'b1, 16'h0000, 0};
    tv[5] = '{1'b1, 16'h0400, 8'h12, 8'hF0,  1'b0, 16'h01E1, 481 + MK};

    repeat (2) @(negedge clk);
    chk("rst_blk_ready", 32'(blk_ready), 32'h1);
    chk("rst_ent_ready", 32'(ent_ready), 32'h0);
    chk("rst_mem_wen", 32'(mem_wen), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_write_base", 32'(write_base), 32'h0);
    chk("rst_blk_done", 32'(blk_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (tv[i].clr) do_clear();
      run_block(tv[i].sz, tv[i].id, tv[i].len, 1'b0, 0);
      chk($sformatf("tv%0d_base", i), 32'(write_base), 32'(tv[i].exp_base));
      chk($sformatf("tv%0d_err", i), 32'(err), 32'(tv[i].exp_err));
      chk($sformatf("tv%0d_nwr", i), 32'(last_nwr), 32'(tv[i].exp_nwr));
    end

    // Valid held low in SRC, then blk_start while the dest word is being written.
    do_clear();
    size = 16'h0040;
    w0 = wr_q.size();
    d0 = done_cnt;
    blk_id = 8'h21; blk_len = 8'd1; blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
    t = 0;
    while (!ent_ready && t < 10) begin @(negedge clk); t++; end
    chk("hold_reach_src", 32'(ent_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_ent_ready", 32'(ent_ready), 32'h1);
      chk("hold_no_write", 32'(wr_q.size() - w0), 32'h1);
    end
    ent_valid = 1'b1; ent_src = 16'hAAAA; ent_dest = 16'hBBBB;
    @(negedge clk);
    ent_valid = 1'b0;
    chk("dest_blk_ready", 32'(blk_ready), 32'h0);
    blk_id = 8'h55; blk_len = 8'd0; blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
    t = 0;
    while (!blk_done && t < 10) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("hold_nwr", 32'(wr_q.size() - w0), 32'(3 + MK));
    if (wr_q.size() - w0 >= 3) begin
      chk("hold_hdr", wr_q[w0], 32'h0000_2101);
      chk("hold_src", wr_q[w0 + 1], 32'h0001_AAAA);
      chk("hold_dst", wr_q[w0 + 2], 32'h0002_BBBB);
    end
`ifdef BLOCK_STORE_ENDMARK_EN
    if (wr_q.size() - w0 >= 4) chk("endmark_word", wr_q[w0 + 3], 32'h0003_0000);
`endif
    chk("hold_base", 32'(write_base), 32'h3);
    chk("hold_done", 32'(done_cnt - d0), 32'h1);
    m_base = 16'h0003;

    // clear and blk_start in the same cycle: clear wins.
    w0 = wr_q.size();
    clear = 1'b1; blk_id = 8'h66; blk_len = 8'd0; blk_start = 1'b1;
    @(negedge clk);
    clear = 1'b0; blk_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("clrwin_no_write", 32'(wr_q.size() - w0), 32'h0);
    chk("clrwin_base", 32'(write_base), 32'h0);
    chk("clrwin_ready", 32'(blk_ready), 32'h1);
    m_base = '0; m_err = 1'b0;

    // Async reset right after a header write.
    run_block(16'h0040, 8'h31, 8'd1, 1'b0, 0);
    blk_id = 8'h44; blk_len = 8'd2; blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
    chk("prerst_hdr_wen", 32'(mem_wen), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_wen", 32'(mem_wen), 32'h0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    chk("midrst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("midrst_base", 32'(write_base), 32'h0);
    chk("midrst_ready", 32'(blk_ready), 32'h1);
    chk("midrst_ent_ready", 32'(ent_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_base = '0; m_err = 1'b0;
    @(negedge clk);

    // Random blocks in a small memory, steering some lengths to land exactly on the end.
    do_clear();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      rem = 48 - int'(m_base);
      case ($urandom_range(0, 9))
        0, 1:    len = (rem % 2 == 1) ? (rem - 1) / 2 : int'($urandom_range(0, 6));
        2:       len = int'($urandom_range(10, 30));
        default: len = int'($urandom_range(0, 6));
      endcase
      run_block(16'h0030, 8'($urandom), 8'(len), 1'b1, 3);
    end

    chk("addr_in_range", 32'(oob_cnt), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
